// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one debug-module DMI port among NUM_MASTERS masters, one transaction in flight.
// dmi_req = {addr[6:0], op[1:0], data[31:0]}, dmi_resp = {data[31:0], resp[1:0]}; DMI_ARB_TIMEOUT_EN adds a response timeout.
module dmi_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rst_ni,
  input  logic [NUM_MASTERS*41-1:0]           m_dmi_req_i,
  input  logic [NUM_MASTERS-1:0]              m_dmi_req_valid_i,
  output logic [NUM_MASTERS-1:0]              m_dmi_req_ready_o,
  input  logic [NUM_MASTERS-1:0]              m_dmi_clear_i,
  output logic [33:0]                         m_dmi_resp_o,
  output logic [NUM_MASTERS-1:0]              m_dmi_resp_valid_o,
  input  logic [NUM_MASTERS-1:0]              m_dmi_resp_ready_i,
  output logic [40:0]                         dm_dmi_req_o,
  output logic                                dm_dmi_req_valid_o,
  input  logic                                dm_dmi_req_ready_i,
  input  logic [33:0]                         dm_dmi_resp_i,
  input  logic                                dm_dmi_resp_valid_i,
  output logic                                dm_dmi_resp_ready_o,
  output logic                                busy_o,
  output logic [$clog2(NUM_MASTERS)-1:0]      owner_o
);

  localparam int REQ_W = 41;
  localparam int RSP_W = 34;
  localparam int IW    = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("dmi_arbiter: parameter out of range");
  end

  // IDLE arbitrate | ISSUE drive DM request | WAIT_RESP await DM response | DELIVER hand response to owner
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DELIVER} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [RSP_W-1:0]  resp_q, resp_d;
  logic              discard_q, discard_d;
  logic              stale;

`ifdef DMI_ARB_TIMEOUT_EN
  logic              stale_q, stale_d;
  logic [15:0]       tmo_q, tmo_d;
  assign stale = stale_q;
`else
  assign stale = 1'b0;
`endif

  logic [NUM_MASTERS-1:0] elig;
  logic [IW-1:0]          win;
  logic                   win_found;
  logic                   clr_owner;
  logic                   disc;

  assign elig      = m_dmi_req_valid_i & ~m_dmi_clear_i;
  assign clr_owner = m_dmi_clear_i[owner_q];
  assign disc      = discard_q | clr_owner;

  always_comb begin
    int            idx;
    logic [IW-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ROUND_ROBIN != 0) begin
        idx = int'(last_grant_q) + 1 + i;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      end else begin
        idx = i;
      end
      idx_w = IW'(idx);
      if (!win_found && elig[idx_w]) begin
        win       = idx_w;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    owner_d             = owner_q;
    last_grant_d        = last_grant_q;
    req_d               = req_q;
    resp_d              = resp_q;
    discard_d           = discard_q;
    m_dmi_req_ready_o   = '0;
    m_dmi_resp_valid_o  = '0;
    dm_dmi_req_valid_o  = 1'b0;
    dm_dmi_resp_ready_o = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
    stale_d             = stale_q;
    tmo_d               = '0;
`endif

    // A response abandoned by a timeout is absorbed whenever it finally shows up.
    if (stale) begin
      dm_dmi_resp_ready_o = 1'b1;
`ifdef DMI_ARB_TIMEOUT_EN
      if (dm_dmi_resp_valid_i) stale_d = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (win_found && !stale && rst_ni) begin
          m_dmi_req_ready_o[win] = 1'b1;
          req_d                  = m_dmi_req_i[win*REQ_W +: REQ_W];
          owner_d                = win;
          last_grant_d           = win;
          discard_d              = 1'b0;
          state_d                = ISSUE;
        end
      end
      ISSUE: begin
        dm_dmi_req_valid_o = 1'b1;
        if (clr_owner) discard_d = 1'b1;
        if (dm_dmi_req_ready_i) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        dm_dmi_resp_ready_o = 1'b1;
        if (clr_owner) discard_d = 1'b1;
        if (dm_dmi_resp_valid_i) begin
          discard_d = 1'b0;
          if (disc) begin
            state_d = IDLE;
          end else begin
            resp_d  = dm_dmi_resp_i;
            state_d = DELIVER;
          end
        end
`ifdef DMI_ARB_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          stale_d   = 1'b1;
          discard_d = 1'b0;
          if (disc) begin
            state_d = IDLE;
          end else begin
            resp_d  = {32'h0, 2'h2};
            state_d = DELIVER;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      DELIVER: begin
        m_dmi_resp_valid_o[owner_q] = 1'b1;
        if (clr_owner || m_dmi_resp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IW'(NUM_MASTERS - 1);
      req_q        <= '0;
      resp_q       <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      resp_q       <= resp_d;
      discard_q    <= discard_d;
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stale_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      stale_q <= stale_d;
      tmo_q   <= tmo_d;
    end
  end
`endif

  assign m_dmi_resp_o = resp_q;
  assign dm_dmi_req_o = req_q;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q != IDLE) | stale;

endmodule
